// File: rtl/state_pack_cit__compress_gather.sv
// -----------------------------------------------------------------------------
// state_pack_cit__compress_gather
//
// Upstream feeder of the 3-bit ciphertext packer. The block takes one 12-bit
// coefficient per cycle, compresses it to KYBER_D bits and gathers 8
// compressed values into a group. It then presents the group, with a
// last-of-polynomial flag, to the 8-coefficient-to-3-byte pack stage.
//
// Double-buffered: seven gather slots plus a separate output register. While
// downstream is ready, a new coefficient is accepted every cycle with no
// bubbles.
//
// Handshakes (both sides): a transfer happens on a rising edge where valid
// and ready are both high. Valid never depends on ready. o_ready depends
// combinationally on i_ready and i_clear. While o_valid is high and i_ready
// is low, o_valid, o_last and all lanes hold stable.
//
// Optional feature macro: STATE_PACK_CIT__COMPRESS_CSUB_EN
//   defined   : inputs in [KYBER_Q, 2*KYBER_Q) are conditionally reduced by
//               KYBER_Q before compression (lazily reduced input)
//   undefined : the raw input value is compressed unchanged
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   i_clear                   sync clear: drops partial/output group, counters
//   i_Coeff, i_valid, o_ready coefficient input handshake
//   oPolyCoeffs0..7           compressed group, lane k = k-th accepted coeff
//   o_valid, i_ready          group output handshake
//   o_last                    group is the final one of the polynomial
// -----------------------------------------------------------------------------
module state_pack_cit__compress_gather #(
  parameter int KYBER_N       = 256,
  parameter int KYBER_Q       = 3329,
  parameter int KYBER_D       = 3,
  parameter int i_Coeff_Width = 12,
  parameter int o_Width       = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clear,
  input  logic [i_Coeff_Width-1:0] i_Coeff,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic [o_Width-1:0]       oPolyCoeffs0,
  output logic [o_Width-1:0]       oPolyCoeffs1,
  output logic [o_Width-1:0]       oPolyCoeffs2,
  output logic [o_Width-1:0]       oPolyCoeffs3,
  output logic [o_Width-1:0]       oPolyCoeffs4,
  output logic [o_Width-1:0]       oPolyCoeffs5,
  output logic [o_Width-1:0]       oPolyCoeffs6,
  output logic [o_Width-1:0]       oPolyCoeffs7,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_last
);

  localparam int NUM_GROUPS = KYBER_N / 8;
  localparam int GCW        = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  // Numerator x*2^D + Q/2 needs one bit of headroom above x*2^D.
  localparam int NUM_W      = i_Coeff_Width + KYBER_D + 1;
  // Largest quotient the numerator can reach for any input value.
  localparam int MAX_K      = (((2 ** i_Coeff_Width) - 1) * (2 ** KYBER_D)
                               + KYBER_Q / 2) / KYBER_Q;

  // ---------------------------------------------------------------------------
  // Compression: c = floor((x*2^D + Q/2) / Q) mod 2^D
  // ---------------------------------------------------------------------------
  logic [i_Coeff_Width-1:0] coeffX;

`ifdef STATE_PACK_CIT__COMPRESS_CSUB_EN
  always_comb begin
    coeffX = i_Coeff;
    if (i_Coeff >= i_Coeff_Width'(KYBER_Q)) begin
      coeffX = i_Coeff - i_Coeff_Width'(KYBER_Q);
    end
  end
`else
  assign coeffX = i_Coeff;
`endif

  logic [NUM_W-1:0]   numer;
  logic [KYBER_D-1:0] compVal;

  assign numer = {1'b0, coeffX, {KYBER_D{1'b0}}} + NUM_W'(KYBER_Q / 2);

  // Comparator ladder in place of a divider. Each threshold k*Q that the
  // numerator reaches adds one to the quotient. The count is kept only
  // KYBER_D bits wide, so the "mod 2^D" wrap happens for free.
  always_comb begin
    compVal = '0;
    for (int k = 1; k <= MAX_K; k++) begin
      if (numer >= NUM_W'(k * KYBER_Q)) begin
        compVal = compVal + KYBER_D'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Gather and output registers
  // ---------------------------------------------------------------------------
  logic [2:0]         fillCnt;
  logic [GCW-1:0]     groupCnt;
  logic [KYBER_D-1:0] gather [0:6];
  logic [o_Width-1:0] lane   [0:7];

  logic outFree;
  logic accept;
  logic loadGroup;
  logic drain;
  logic lastGroup;

  assign outFree   = !o_valid | i_ready;
  // Stall only when the 8th coefficient would have to load into an output
  // register that is still held by downstream.
  assign o_ready   = !i_clear & ((fillCnt != 3'd7) | outFree);
  assign accept    = i_valid & o_ready;
  assign loadGroup = accept & (fillCnt == 3'd7);
  assign drain     = o_valid & i_ready;
  assign lastGroup = (groupCnt == GCW'(NUM_GROUPS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fillCnt  <= '0;
      groupCnt <= '0;
      o_valid  <= 1'b0;
      o_last   <= 1'b0;
      for (int k = 0; k < 7; k++) gather[k] <= '0;
      for (int k = 0; k < 8; k++) lane[k]   <= '0;
    end else if (i_clear) begin
      // Data registers may keep stale values; only control state is dropped.
      fillCnt  <= '0;
      groupCnt <= '0;
      o_valid  <= 1'b0;
      o_last   <= 1'b0;
    end else begin
      if (accept) begin
        fillCnt <= fillCnt + 3'd1;  // 7 wraps back to 0
        if (fillCnt != 3'd7) begin
          gather[fillCnt] <= compVal;
        end
      end
      if (loadGroup) begin
        // A load takes precedence over a drain. When both happen in the same
        // cycle, the old group leaves and the new one arrives with o_valid
        // staying high.
        for (int k = 0; k < 7; k++) lane[k] <= o_Width'(gather[k]);
        lane[7]  <= o_Width'(compVal);
        o_valid  <= 1'b1;
        o_last   <= lastGroup;
        groupCnt <= lastGroup ? '0 : groupCnt + GCW'(1);
      end else if (drain) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end
    end
  end

  assign oPolyCoeffs0 = lane[0];
  assign oPolyCoeffs1 = lane[1];
  assign oPolyCoeffs2 = lane[2];
  assign oPolyCoeffs3 = lane[3];
  assign oPolyCoeffs4 = lane[4];
  assign oPolyCoeffs5 = lane[5];
  assign oPolyCoeffs6 = lane[6];
  assign oPolyCoeffs7 = lane[7];

endmodule

// File: tb/tb_state_pack_cit__compress_gather.sv
// -----------------------------------------------------------------------------
// tb_state_pack_cit__compress_gather
//
// Self-checking bench for state_pack_cit__compress_gather. A negedge
// scoreboard keeps a behavioural model: a list of compressed values for the
// partial group, a coefficient count per polynomial, and an expected queue of
// whole groups. Scenario tasks drive randomized streams and check their
// specific behaviour inline.
// Build with +define+STATE_PACK_CIT__COMPRESS_CSUB_EN to also exercise the
// conditional-subtract input path.
// -----------------------------------------------------------------------------
module tb_state_pack_cit__compress_gather;

  localparam int N  = 256;
  localparam int Q  = 3329;
  localparam int D  = 3;
  localparam int CW = 12;
  localparam int OW = 8;
  localparam int GW = 8 * OW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          i_clear = 1'b0;
  logic [CW-1:0] i_Coeff = '0;
  logic          i_valid = 1'b0;
  logic          i_ready = 1'b1;
  logic          o_ready, o_valid, o_last;
  logic [OW-1:0] p0, p1, p2, p3, p4, p5, p6, p7;
  logic [OW-1:0] lanes [8];

  assign lanes[0] = p0; assign lanes[1] = p1; assign lanes[2] = p2;
  assign lanes[3] = p3; assign lanes[4] = p4; assign lanes[5] = p5;
  assign lanes[6] = p6; assign lanes[7] = p7;

  state_pack_cit__compress_gather #(
    .KYBER_N(N), .KYBER_Q(Q), .KYBER_D(D), .i_Coeff_Width(CW), .o_Width(OW)
  ) dut (
    .clk(clk), .rst(rst), .i_clear(i_clear),
    .i_Coeff(i_Coeff), .i_valid(i_valid), .o_ready(o_ready),
    .oPolyCoeffs0(p0), .oPolyCoeffs1(p1), .oPolyCoeffs2(p2), .oPolyCoeffs3(p3),
    .oPolyCoeffs4(p4), .oPolyCoeffs5(p5), .oPolyCoeffs6(p6), .oPolyCoeffs7(p7),
    .o_valid(o_valid), .i_ready(i_ready), .o_last(o_last)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  function automatic int ref_comp(input int v);
    int x;
    x = v;
`ifdef STATE_PACK_CIT__COMPRESS_CSUB_EN
    if (x >= Q) x = x - Q;
`endif
    return ((x * (2 ** D) + Q / 2) / Q) % (2 ** D);
  endfunction

  function automatic logic [GW-1:0] act_group();
    return {o_last, p7, p6, p5, p4, p3, p2, p1, p0};
  endfunction

  // ---------------- scoreboard ----------------
  logic [GW-1:0] exp_q [$];
  int            part_q [$];
  int            poly_cnt = 0;
  logic [GW-1:0] mon_g;
  logic [GW-1:0] mon_exp;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      part_q.delete();
      poly_cnt = 0;
    end else begin
      checks++;
      if (o_valid !== (exp_q.size() != 0)) begin
        failures++;
        $display("FAIL sb_valid: o_valid=%0b expected %0b at %0t",
                 o_valid, exp_q.size() != 0, $time);
      end
      if (i_clear) begin
        exp_q.delete();
        part_q.delete();
        poly_cnt = 0;
      end else begin
        if (o_valid && i_ready && exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          checks++;
          if (act_group() !== mon_exp) begin
            failures++;
            $display("FAIL sb_group: got %h expected %h at %0t",
                     act_group(), mon_exp, $time);
          end
        end
        if (i_valid && o_ready) begin
          part_q.push_back(ref_comp(int'(i_Coeff)));
          poly_cnt++;
          if (part_q.size() == 8) begin
            mon_g = '0;
            for (int k = 0; k < 8; k++) mon_g[k*OW +: OW] = OW'(part_q[k]);
            mon_g[GW-1] = ((poly_cnt % N) == 0);
            exp_q.push_back(mon_g);
            part_q.delete();
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    i_valid = 1'b0;
    i_clear = 1'b0;
    i_ready = 1'b1;
    i_Coeff = '0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  // Hold a coefficient on the input until it is accepted (bounded wait).
  task automatic send(input logic [CW-1:0] v);
    bit ok;
    ok      = 1'b0;
    i_valid = 1'b1;
    i_Coeff = v;
    for (int g = 0; g < 100; g++) begin
      @(negedge clk);
      ok = o_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: o_ready=0 for 100 cycles, required 1");
    end
  endtask

  function automatic logic [CW-1:0] rnd();
    return CW'($urandom_range(0, 4095));
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (act_group() !== '0 || o_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_held: group=%h valid=%0b required 0", act_group(), o_valid);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (o_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: o_ready=%0b required 1", o_ready);
    end
    checks++;
    if (o_valid !== 1'b0 || o_last !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: valid=%0b last=%0b required 0 0", o_valid, o_last);
    end
  endtask

  task automatic test_points();
    int pts [8] = '{0, 208, 209, 1664, 1665, 2704, 3328, 4095};
    int exp [8] = '{0, 0, 1, 4, 4, 6, 0, 2};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(CW'(pts[i]));
      if (i == 6) begin
        checks++;
        if (o_valid !== 1'b0) begin
          failures++;
          $display("FAIL points_early_valid: o_valid=%0b required 0", o_valid);
        end
      end
    end
    i_valid = 1'b0;
    checks++;
    if (o_valid !== 1'b1 || o_last !== 1'b0) begin
      failures++;
      $display("FAIL points_latency: valid=%0b last=%0b required 1 0", o_valid, o_last);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (lanes[k] !== OW'(exp[k])) begin
        failures++;
        $display("FAIL points_lane%0d: got %0d required %0d", k, lanes[k], exp[k]);
      end
    end
    repeat (2) tick();
  endtask

  task automatic test_full_poly();
    int groups, last_cnt, last_bad;
    groups = 0; last_cnt = 0; last_bad = 0;
    do_reset();
    for (int i = 0; i < 2 * N + 3; i++) begin
      i_valid = (i < 2 * N);
      i_Coeff = rnd();
      @(negedge clk);
      if (i < 2 * N) begin
        checks++;
        if (o_ready !== 1'b1) begin
          failures++;
          $display("FAIL full_ready: o_ready=%0b required 1 at coeff %0d", o_ready, i);
        end
      end
      if (o_valid && i_ready) begin
        groups++;
        if (o_last) last_cnt++;
        if (o_last !== ((groups % (N / 8)) == 0)) last_bad++;
      end
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    checks++;
    if (groups != 2 * N / 8) begin
      failures++;
      $display("FAIL full_groups: got %0d required %0d", groups, 2 * N / 8);
    end
    checks++;
    if (last_cnt != 2 || last_bad != 0) begin
      failures++;
      $display("FAIL full_last: last_cnt=%0d misplaced=%0d required 2 0", last_cnt, last_bad);
    end
  endtask

  task automatic test_backpressure();
    int acc, early_stall, unstable;
    bit have;
    logic [GW-1:0] cap;
    acc = 0; early_stall = 0; unstable = 0; have = 1'b0; cap = '0;
    do_reset();
    i_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      i_valid = 1'b1;
      i_Coeff = rnd();
      @(negedge clk);
      if (o_ready) acc++;
      else if (acc != 15) early_stall++;
      if (o_valid) begin
        if (!have) begin cap = act_group(); have = 1'b1; end
        else if (act_group() !== cap) unstable++;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (acc != 15) begin
      failures++;
      $display("FAIL bp_accepts: got %0d required 15", acc);
    end
    checks++;
    if (early_stall != 0) begin
      failures++;
      $display("FAIL bp_early_stall: got %0d stalls before fill, required 0", early_stall);
    end
    checks++;
    if (!have || unstable != 0) begin
      failures++;
      $display("FAIL bp_hold: held=%0b changes=%0d required 1 0", have, unstable);
    end
    i_ready = 1'b1;
    i_Coeff = rnd();
    @(negedge clk);
    checks++;
    if (o_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_ready: o_ready=%0b required 1", o_ready);
    end
    if (o_ready) acc++;
    @(posedge clk);
    #1;
    for (int c = 0; c < 100 && acc < 32; c++) begin
      i_Coeff = rnd();
      @(negedge clk);
      if (o_ready) acc++;
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if (acc != 32 || o_valid !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL bp_drain: acc=%0d valid=%0b pending=%0d required 32 0 0",
               acc, o_valid, exp_q.size());
    end
  endtask

  task automatic test_clear();
    int groups, last_cnt, last_bad, acc;
    int first_ref [8];
    groups = 0; last_cnt = 0; last_bad = 0; acc = 0;
    do_reset();
    for (int i = 0; i < 5; i++) send(rnd());
    i_valid = 1'b1;
    i_clear = 1'b1;
    i_Coeff = rnd();
    @(negedge clk);
    checks++;
    if (o_ready !== 1'b0) begin
      failures++;
      $display("FAIL clear_ready: o_ready=%0b required 0", o_ready);
    end
    @(posedge clk);
    #1;
    i_clear = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_last !== 1'b0) begin
      failures++;
      $display("FAIL clear_flags: valid=%0b last=%0b required 0 0", o_valid, o_last);
    end
    for (int i = 0; i < N + 3; i++) begin
      i_valid = (i < N);
      i_Coeff = rnd();
      if (i < 8) first_ref[i] = ref_comp(int'(i_Coeff));
      @(negedge clk);
      if (o_valid && i_ready) begin
        groups++;
        if (groups == 1) begin
          for (int k = 0; k < 8; k++) begin
            checks++;
            if (lanes[k] !== OW'(first_ref[k])) begin
              failures++;
              $display("FAIL clear_lane%0d: got %0d required %0d", k, lanes[k], first_ref[k]);
            end
          end
        end
        if (o_last) last_cnt++;
        if (o_last !== (groups == N / 8)) last_bad++;
      end
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    checks++;
    if (groups != N / 8 || last_cnt != 1 || last_bad != 0) begin
      failures++;
      $display("FAIL clear_last: groups=%0d last_cnt=%0d misplaced=%0d required %0d 1 0",
               groups, last_cnt, last_bad, N / 8);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    i_ready = 1'b0;
    for (int i = 0; i < 11; i++) send(rnd());
    i_valid = 1'b0;
    checks++;
    if (o_valid !== 1'b1) begin
      failures++;
      $display("FAIL arst_setup: o_valid=%0b required 1", o_valid);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (o_valid !== 1'b0 || act_group() !== '0) begin
      failures++;
      $display("FAIL arst_immediate: valid=%0b group=%h required 0 0", o_valid, act_group());
    end
    repeat (2) tick();
    rst = 1'b0;
    i_ready = 1'b1;
    tick();
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      failures++;
      $display("FAIL arst_release: ready=%0b valid=%0b required 1 0", o_ready, o_valid);
    end
    // A fresh group must start at lane 0; the scoreboard checks its content.
    for (int i = 0; i < 8; i++) send(rnd());
    i_valid = 1'b0;
    repeat (3) tick();
  endtask

`ifdef STATE_PACK_CIT__COMPRESS_CSUB_EN
  task automatic test_csub();
    int pts [8] = '{3329, 3537, 4993, 0, 208, 1664, 3328, 3330};
    int exp [8] = '{0, 0, 4, 0, 0, 4, 0, 0};
    do_reset();
    for (int i = 0; i < 8; i++) send(CW'(pts[i]));
    i_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (lanes[k] !== OW'(exp[k])) begin
        failures++;
        $display("FAIL csub_lane%0d: got %0d required %0d", k, lanes[k], exp[k]);
      end
    end
    repeat (2) tick();
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_points();
    test_full_poly();
    test_backpressure();
    test_clear();
    test_async_reset();
`ifdef STATE_PACK_CIT__COMPRESS_CSUB_EN
    test_csub();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL final_pending: %0d groups never emitted, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
